instr_mem_responder: RTL and testbench

- Instruction-side memory responder for the Harvard MIPS core; it is the other end of the program counter's fetch interface.
- Accepts a fetch request (byte address) from the PC/fetch stage and returns the 32-bit instruction word after a fixed, parameterised latency.
- Flags misaligned and out-of-range fetches, and detects the fetch of address 0x00000000 as the end-of-program condition.
- Contents are preloaded through a dedicated write port, so the same block serves simulation benches and the synthesised core.

---
 rtl/instr_mem_responder.sv | 137 +++++++++++++
 tb/tb_instr_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-side memory responder: accepts byte-address fetches from the PC
// and returns the stored word after LATENCY cycles, flagging faults and halt.
module instr_mem_responder #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned IDX_W        = 10,
  parameter int unsigned LATENCY      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [31:0]      addr,
  output logic             fetch_ready,
  output logic             instr_valid,
  output logic [31:0]      instruction_word,
  output logic             fault,
  output logic             halt,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [31:0]      load_data
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_WAIT   = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;
  localparam logic [1:0]  S_HALTED = 2'd3;
  localparam logic [2:0]  LAT_CNT  = 3'(LATENCY - 1);
  localparam logic [29:0] DEPTH30  = 30'(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;
  logic        fault_q, fault_d;
  logic        halt_q, halt_d;

  logic             accept;
  logic             respond;
  logic [31:0]      resp_addr;
  logic [29:0]      off_hi;
  logic [IDX_W-1:0] rd_idx;
  logic             misaligned;
  logic             out_of_range;

  assign fetch_ready      = reset && (state_q == S_IDLE || state_q == S_RESP);
  assign accept           = fetch_req && fetch_ready;
  assign instr_valid      = valid_q;
  assign instruction_word = word_q;
  assign fault            = fault_q;
  assign halt             = halt_q;

  // With LATENCY==1 the response is produced on the accept edge itself,
  // so the decode looks at the live address rather than the latched one.
  always_comb begin
    resp_addr    = (state_q == S_WAIT) ? addr_q : addr;
    off_hi       = 30'((resp_addr - RESET_VECTOR) >> 2);
    rd_idx       = off_hi[IDX_W-1:0];
    misaligned   = (resp_addr[1:0] != 2'b00);
    out_of_range = (resp_addr < RESET_VECTOR) || (off_hi >= DEPTH30);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    word_d  = word_q;
    fault_d = fault_q;
    halt_d  = halt_q;
    respond = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept) begin
          if (addr == 32'h0000_0000) begin
            halt_d  = 1'b1;
            state_d = S_HALTED;
          end else begin
            addr_d = addr;
            if (LATENCY == 1) begin
              respond = 1'b1;
              state_d = S_RESP;
            end else begin
              cnt_d   = LAT_CNT;
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          respond = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_HALTED;
    endcase
    if (respond) begin
      valid_d = 1'b1;
      fault_d = misaligned || out_of_range;
      word_d  = (misaligned || out_of_range) ? '0 : mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      fault_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      fault_q <= fault_d;
      halt_q  <= halt_d;
    end
  end

  // Preload port is independent of reset so contents can be loaded while held in reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: one instance at LATENCY=1 (a) and
// one at LATENCY=3 (b), sharing a clock.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a, req_a, rdy_a, val_a, flt_a, hlt_a, ld_a;
  logic [31:0] addr_a, word_a, ldd_a;
  logic [9:0]  lda_a;
  logic        rst_b, req_b, rdy_b, val_b, flt_b, hlt_b, ld_b;
  logic [31:0] addr_b, word_b, ldd_b;
  logic [9:0]  lda_b;

  instr_mem_responder #(.RESET_VECTOR(32'hBFC00000), .DEPTH_WORDS(1024), .IDX_W(10), .LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a), .fetch_req(req_a), .addr(addr_a), .fetch_ready(rdy_a),
    .instr_valid(val_a), .instruction_word(word_a), .fault(flt_a), .halt(hlt_a),
    .load_en(ld_a), .load_addr(lda_a), .load_data(ldd_a));

  instr_mem_responder #(.RESET_VECTOR(32'hBFC00000), .DEPTH_WORDS(1024), .IDX_W(10), .LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b), .fetch_req(req_b), .addr(addr_b), .fetch_ready(rdy_b),
    .instr_valid(val_b), .instruction_word(word_b), .fault(flt_b), .halt(hlt_b),
    .load_en(ld_b), .load_addr(lda_b), .load_data(ldd_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; req_a = 1'b1; req_b = 1'b1;
    addr_a = 32'hBFC00000; addr_b = 32'hBFC00000;
    ld_a = 1'b1; lda_a = 10'd0; ldd_a = 32'h00621820;
    ld_b = 1'b1; lda_b = 10'd0; ldd_b = 32'h00621820;
    tick();
    lda_a = 10'd1; ldd_a = 32'h8C430004;
    lda_b = 10'd1; ldd_b = 32'h8C430004;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", val_a); end
    checks++; if (word_a !== 32'h0) begin errors++; $display("FAIL reset_word: got %h expected 00000000", word_a); end
    checks++; if ({flt_a, hlt_a} !== 2'b00) begin errors++; $display("FAIL reset_fault_halt: got %b expected 00", {flt_a, hlt_a}); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", rdy_a); end
    req_a = 1'b0; req_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    checks++; if ({rdy_a, rdy_b} !== 2'b11) begin errors++; $display("FAIL reset_release_ready: got %b expected 11", {rdy_a, rdy_b}); end
  endtask

  task automatic test_single();
    req_a = 1'b1; addr_a = 32'hBFC00000;
    tick();
    req_a = 1'b0;
    checks++; if (val_a !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", val_a); end
    checks++; if (word_a !== 32'h00621820) begin errors++; $display("FAIL single_word: got %h expected 00621820", word_a); end
    checks++; if (flt_a !== 1'b0) begin errors++; $display("FAIL single_fault: got %b expected 0", flt_a); end
    tick();
    checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", val_a); end
    checks++; if (word_a !== 32'h00621820) begin errors++; $display("FAIL single_hold: got %h expected 00621820", word_a); end
  endtask

  task automatic test_back_to_back();
    req_a = 1'b1; addr_a = 32'hBFC00000;
    tick();
    checks++; if ({val_a, rdy_a} !== 2'b11) begin errors++; $display("FAIL b2b_first_valid_ready: got %b expected 11", {val_a, rdy_a}); end
    checks++; if (word_a !== 32'h00621820) begin errors++; $display("FAIL b2b_first_word: got %h expected 00621820", word_a); end
    addr_a = 32'hBFC00004;
    tick();
    req_a = 1'b0;
    checks++; if ({val_a, rdy_a} !== 2'b11) begin errors++; $display("FAIL b2b_second_valid_ready: got %b expected 11", {val_a, rdy_a}); end
    checks++; if (word_a !== 32'h8C430004) begin errors++; $display("FAIL b2b_second_word: got %h expected 8C430004", word_a); end
    tick();
    checks++; if ({val_a, rdy_a} !== 2'b01) begin errors++; $display("FAIL b2b_idle: got %b expected 01", {val_a, rdy_a}); end
  endtask

  task automatic test_latency3();
    req_b = 1'b1; addr_b = 32'hBFC00004;
    tick();
    req_b = 1'b0; addr_b = 32'hBFC00008;
    checks++; if ({val_b, rdy_b} !== 2'b00) begin errors++; $display("FAIL lat3_cycle1: got %b expected 00", {val_b, rdy_b}); end
    tick();
    checks++; if ({val_b, rdy_b} !== 2'b00) begin errors++; $display("FAIL lat3_cycle2: got %b expected 00", {val_b, rdy_b}); end
    tick();
    checks++; if ({val_b, rdy_b, flt_b} !== 3'b110) begin errors++; $display("FAIL lat3_resp: got %b expected 110", {val_b, rdy_b, flt_b}); end
    checks++; if (word_b !== 32'h8C430004) begin errors++; $display("FAIL lat3_word: got %h expected 8C430004", word_b); end
    tick();
    checks++; if (val_b !== 1'b0) begin errors++; $display("FAIL lat3_pulse: got %b expected 0", val_b); end
  endtask

  task automatic test_faults();
    logic [31:0] bad [3];
    bad[0] = 32'hBFC00002; bad[1] = 32'hBFC01000; bad[2] = 32'h00400000;
    for (int i = 0; i < 3; i++) begin
      req_a = 1'b1; addr_a = bad[i];
      tick();
      req_a = 1'b0;
      checks++; if ({val_a, flt_a} !== 2'b11) begin errors++; $display("FAIL fault_%0d_flag: got %b expected 11", i, {val_a, flt_a}); end
      checks++; if (word_a !== 32'h0) begin errors++; $display("FAIL fault_%0d_word: got %h expected 00000000", i, word_a); end
      tick();
    end
    req_a = 1'b1; addr_a = 32'hBFC00FFC;
    tick();
    req_a = 1'b0;
    checks++; if ({val_a, flt_a} !== 2'b10) begin errors++; $display("FAIL fault_last_index: got %b expected 10", {val_a, flt_a}); end
    tick();
  endtask

  task automatic test_halt();
    req_a = 1'b1; addr_a = 32'h00000000;
    tick();
    checks++; if ({val_a, hlt_a, rdy_a} !== 3'b010) begin errors++; $display("FAIL halt_enter: got %b expected 010", {val_a, hlt_a, rdy_a}); end
    addr_a = 32'hBFC00000;
    tick();
    tick();
    checks++; if ({val_a, hlt_a, rdy_a} !== 3'b010) begin errors++; $display("FAIL halt_ignore_req: got %b expected 010", {val_a, hlt_a, rdy_a}); end
    req_a = 1'b0; rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    #1;
    checks++; if ({hlt_a, rdy_a} !== 2'b01) begin errors++; $display("FAIL halt_cleared: got %b expected 01", {hlt_a, rdy_a}); end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    seen = 1'b0;
    req_b = 1'b1; addr_b = 32'hBFC00000;
    tick();
    req_b = 1'b0; rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = seen | val_b;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midwait_no_resp: got %b expected 0", seen); end
    checks++; if ({word_b, rdy_b} !== {32'h0, 1'b1}) begin errors++; $display("FAIL midwait_state: got %h/%b expected 00000000/1", word_b, rdy_b); end
  endtask

  task automatic test_read_before_write();
    req_a = 1'b1; addr_a = 32'hBFC00000;
    ld_a = 1'b1; lda_a = 10'd0; ldd_a = 32'hFFFFFFFF;
    tick();
    ld_a = 1'b0;
    checks++; if ({val_a, word_a} !== {1'b1, 32'h00621820}) begin errors++; $display("FAIL rbw_old: got %b/%h expected 1/00621820", val_a, word_a); end
    tick();
    req_a = 1'b0;
    checks++; if ({val_a, word_a} !== {1'b1, 32'hFFFFFFFF}) begin errors++; $display("FAIL rbw_new: got %b/%h expected 1/FFFFFFFF", val_a, word_a); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_latency3();
    test_faults();
    test_halt();
    test_reset_mid_wait();
    test_read_before_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
